// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg -- shared constants and elaboration-time helpers for seq_detect.
//
//   PAT_LEN_DEF / PATTERN_DEF : default target sequence (MSB entered first)
//   TIMEOUT_CYC_DEF           : default idle timeout in clk cycles
//   CNT_W / PROG_W            : widths of match_cnt and progress
//   seq_next_len()            : KMP-style next prefix length for one new bit
//   seq_border()              : overlap fallback length after a full match
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int         PAT_LEN_DEF     = 4;
    localparam logic [7:0] PATTERN_DEF     = 8'b0000_1011;
    localparam int         TIMEOUT_CYC_DEF = 100_000_000;
    localparam int         CNT_W           = 8;
    localparam int         PROG_W          = 3;

    // Longest prefix of the pattern that is a suffix of
    // (first p pattern bits, then b). The pattern occupies pat[len-1:0],
    // pat[len-1] being the first bit entered. Result range 0..len.
    function automatic int seq_next_len(input logic [7:0] pat, input int len,
                                        input int p, input logic b);
        logic [8:0] s;
        int         res;
        logic       ok;
        s   = '0;
        res = 0;
        // s[0] is the oldest bit of the candidate history
        for (int i = 0; i < 8; i++)
            if (i < p) s[i] = pat[len-1-i];
        s[p] = b;
        for (int k = 1; k <= 8; k++) begin
            if (k <= p + 1 && k <= len) begin
                ok = 1'b1;
                for (int j = 0; j < 8; j++)
                    if (j < k)
                        if (s[p+1-k+j] != pat[len-1-j]) ok = 1'b0;
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    // Longest proper prefix of the pattern that is also its suffix; this is
    // where progress restarts after a completed match so overlaps are found.
    function automatic int seq_border(input logic [7:0] pat, input int len);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < 8; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int j = 0; j < 8; j++)
                    if (j < k)
                        if (pat[len-1-j] != pat[k-1-j]) ok = 1'b0;
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// ---------------------------------------------------------------------------
// idle_timer -- counts idle cycles while run is high; flags expiry.
//
//   clk      in  system clock
//   clr_in   in  async active-high reset
//   run      in  count enable; counter is held at 0 while low
//   restart  in  synchronous clear (has priority over counting)
//   expired  out high in the cycle the count sits at TIMEOUT_CYC-1 with run
// ---------------------------------------------------------------------------
module idle_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic clr_in,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int         W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        // expiry wraps to 0 so the timer does not re-fire immediately
        if (restart || !run || expired) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge clr_in) begin
        if (clr_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seq_detect.sv
// ---------------------------------------------------------------------------
// seq_detect -- button-strobe serial pattern detector with overlap support.
//
//   clk        in   system clock
//   clr_in     in   async active-high reset
//   pulse_0    in   strobe: enter bit 0
//   pulse_1    in   strobe: enter bit 1
//   match      out  one-cycle pulse, PATTERN just completed
//   err        out  one-cycle pulse, both strobes seen together
//   timeout    out  one-cycle pulse, partial progress dropped on idle
//   match_cnt  out  saturating match count
//   progress   out  matched prefix length (0..PAT_LEN-1)
// ---------------------------------------------------------------------------
module seq_detect
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN     = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN     = PAT_LEN'(PATTERN_DEF),
    parameter int                 TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              clr_in,
    input  logic              pulse_0,
    input  logic              pulse_1,
    output logic              match,
    output logic              err,
    output logic              timeout,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [PROG_W-1:0] progress
);

    localparam logic [3:0]        FULL     = 4'(PAT_LEN);
    localparam logic [PROG_W-1:0] FALLBACK = PROG_W'(seq_border(8'(PATTERN), PAT_LEN));

    // Transition table [progress][bit] built at elaboration; rows beyond
    // PAT_LEN-1 are unreachable and tied to 0.
    logic [7:0][1:0][3:0] nxt_tbl;

    for (genvar gp = 0; gp < 8; gp++) begin : g_row
        for (genvar gb = 0; gb < 2; gb++) begin : g_col
            if (gp < PAT_LEN) begin : g_live
                assign nxt_tbl[gp][gb] =
                    4'(seq_next_len(8'(PATTERN), PAT_LEN, gp, 1'(gb)));
            end else begin : g_dead
                assign nxt_tbl[gp][gb] = 4'd0;
            end
        end
    end

    logic [PROG_W-1:0] progress_q, progress_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic              match_q, match_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic              accept, expired;
    logic [3:0]        nxt_len;

    assign accept  = pulse_0 ^ pulse_1;
    assign nxt_len = nxt_tbl[progress_q][pulse_1];

    idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle (
        .clk     (clk),
        .clr_in  (clr_in),
        .run     (progress_q != '0),
        .restart (accept),
        .expired (expired)
    );

    always_comb begin
        progress_d  = progress_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        err_d       = pulse_0 & pulse_1;
        timeout_d   = 1'b0;
        // an accepted bit takes precedence over a coincident timeout
        if (accept) begin
            if (nxt_len == FULL) begin
                match_d    = 1'b1;
                progress_d = FALLBACK;
                if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
            end else begin
                progress_d = nxt_len[PROG_W-1:0];
            end
        end else if (expired) begin
            progress_d = '0;
            timeout_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr_in) begin
        if (clr_in) begin
            progress_q  <= '0;
            match_cnt_q <= '0;
            match_q     <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            progress_q  <= progress_d;
            match_cnt_q <= match_cnt_d;
            match_q     <= match_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign match     = match_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign match_cnt = match_cnt_q;
    assign progress  = progress_q;

endmodule

// File: tb/tb_seq_detect.sv
// ---------------------------------------------------------------------------
// tb_seq_detect -- directed self-checking bench for seq_detect
// (PATTERN 1011, TIMEOUT_CYC 10).
// ---------------------------------------------------------------------------
module tb_seq_detect;

    logic       clk = 1'b0;
    logic       clr_in = 1'b1;
    logic       pulse_0 = 1'b0;
    logic       pulse_1 = 1'b0;
    logic       match, err, timeout;
    logic [7:0] match_cnt;
    logic [2:0] progress;

    int tests = 0;
    int fails = 0;

    seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .TIMEOUT_CYC(10)) dut (
        .clk       (clk),
        .clr_in    (clr_in),
        .pulse_0   (pulse_0),
        .pulse_1   (pulse_1),
        .match     (match),
        .err       (err),
        .timeout   (timeout),
        .match_cnt (match_cnt),
        .progress  (progress)
    );

    always #5 clk = ~clk;

    // one clock with the given strobes; returns 1 time unit after the edge
    task automatic step(input logic p0, input logic p1);
        pulse_0 = p0;
        pulse_1 = p1;
        @(posedge clk);
        #1;
        pulse_0 = 1'b0;
        pulse_1 = 1'b0;
    endtask

    task automatic do_reset();
        clr_in = 1'b1;
        @(posedge clk);
        #1;
        clr_in = 1'b0;
    endtask

    task automatic test_reset();
        clr_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({match, err, timeout, match_cnt, progress} !== 14'd0) begin
            fails++;
            $display("FAIL reset_state: got m=%b e=%b t=%b cnt=%0d prog=%0d, want all 0",
                     match, err, timeout, match_cnt, progress);
        end
        clr_in = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] exp_prog [3] = '{3'd1, 3'd2, 3'd3};
        logic       bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(~bits[i], bits[i]);
            tests++;
            if (progress !== exp_prog[i] || match !== 1'b0) begin
                fails++;
                $display("FAIL basic_prog[%0d]: got prog=%0d m=%b, want prog=%0d m=0",
                         i, progress, match, exp_prog[i]);
            end
        end
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b1 || match_cnt !== 8'd1 || progress !== 3'd1) begin
            fails++;
            $display("FAIL basic_match: got m=%b cnt=%0d prog=%0d, want m=1 cnt=1 prog=1",
                     match, match_cnt, progress);
        end
        step(1'b0, 1'b0);
        tests++;
        if (match !== 1'b0) begin
            fails++;
            $display("FAIL basic_match_one_cycle: got m=%b, want 0", match);
        end
    endtask

    task automatic test_overlap();
        logic bits [7]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_m [7]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int   nmatch = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(~bits[i], bits[i]);
            if (match === 1'b1) nmatch++;
            tests++;
            if (match !== exp_m[i]) begin
                fails++;
                $display("FAIL overlap_match[%0d]: got %b, want %b", i, match, exp_m[i]);
            end
        end
        tests++;
        if (nmatch != 2 || match_cnt !== 8'd2) begin
            fails++;
            $display("FAIL overlap_count: got pulses=%0d cnt=%0d, want 2 and 2",
                     nmatch, match_cnt);
        end
    endtask

    task automatic test_err();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        tests++;
        if (err !== 1'b1 || progress !== 3'd2 || match !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse: got e=%b prog=%0d m=%b, want e=1 prog=2 m=0",
                     err, progress, match);
        end
        step(1'b0, 1'b0);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_one_cycle: got e=%b, want 0", err);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b1 || match_cnt !== 8'd1) begin
            fails++;
            $display("FAIL err_then_match: got m=%b cnt=%0d, want m=1 cnt=1", match, match_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0);
            tests++;
            if (timeout !== 1'b0 || progress !== 3'd2) begin
                fails++;
                $display("FAIL timeout_early[%0d]: got t=%b prog=%0d, want t=0 prog=2",
                         i, timeout, progress);
            end
        end
        step(1'b0, 1'b0);
        tests++;
        if (timeout !== 1'b1 || progress !== 3'd0) begin
            fails++;
            $display("FAIL timeout_fire: got t=%b prog=%0d, want t=1 prog=0", timeout, progress);
        end
        step(1'b0, 1'b0);
        tests++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_one_cycle: got t=%b, want 0", timeout);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b0 || progress !== 3'd1) begin
            fails++;
            $display("FAIL timeout_no_match: got m=%b prog=%0d, want m=0 prog=1", match, progress);
        end
    endtask

    // accepted bit on the expiry cycle wins over the timeout
    task automatic test_timeout_race();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        tests++;
        if (timeout !== 1'b0 || progress !== 3'd3) begin
            fails++;
            $display("FAIL race_bit_wins: got t=%b prog=%0d, want t=0 prog=3", timeout, progress);
        end
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b1) begin
            fails++;
            $display("FAIL race_match: got m=%b, want 1", match);
        end
    endtask

    // err does not restart the idle timer; idle state never times out
    task automatic test_timeout_err_idle();
        int seen = 0;
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (3) begin
            step(1'b0, 1'b0);
            if (timeout === 1'b1) seen++;
        end
        step(1'b0, 1'b0);
        tests++;
        if (seen != 0 || timeout !== 1'b1 || progress !== 3'd0) begin
            fails++;
            $display("FAIL err_keeps_timer: got early=%0d t=%b prog=%0d, want 0/1/0",
                     seen, timeout, progress);
        end
        seen = 0;
        do_reset();
        repeat (25) begin
            step(1'b0, 1'b0);
            if (timeout === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL idle_no_timeout: got %0d pulses, want 0", seen);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_cnt;
        do_reset();
        for (int r = 1; r <= 257; r++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
            exp_cnt = (r < 255) ? 8'(r) : 8'd255;
            tests++;
            if (match !== 1'b1 || match_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL sat_round[%0d]: got m=%b cnt=%0d, want m=1 cnt=%0d",
                         r, match, match_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_async_clr();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        tests++;
        if (progress !== 3'd3 || match_cnt !== 8'd1) begin
            fails++;
            $display("FAIL clr_setup: got prog=%0d cnt=%0d, want prog=3 cnt=1",
                     progress, match_cnt);
        end
        #1 clr_in = 1'b1;
        #1;
        tests++;
        if ({match, err, timeout, match_cnt, progress} !== 14'd0) begin
            fails++;
            $display("FAIL clr_async: got m=%b e=%b t=%b cnt=%0d prog=%0d, want all 0",
                     match, err, timeout, match_cnt, progress);
        end
        @(posedge clk);
        #3 clr_in = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b0 || progress !== 3'd3) begin
            fails++;
            $display("FAIL clr_restart_prog: got m=%b prog=%0d, want m=0 prog=3", match, progress);
        end
        step(1'b0, 1'b1);
        tests++;
        if (match !== 1'b1 || match_cnt !== 8'd1) begin
            fails++;
            $display("FAIL clr_restart_match: got m=%b cnt=%0d, want m=1 cnt=1", match, match_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_err();
        test_timeout();
        test_timeout_race();
        test_timeout_err_idle();
        test_saturate();
        test_async_clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
